// File: rtl/joypad.sv
// Joypad controller for the P1 register at 0xFF00: two-flop synchroniser,
// per-button debounce, group select register, read mux and interrupt pulse.
module joypad #(
  parameter int unsigned DEBOUNCE = 20000,
  parameter int unsigned CW       = 16
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [15:0] address,
  input  logic [7:0]  outdata,
  output logic [7:0]  data,
  input  logic        load,
  input  logic        store,
  input  logic [7:0]  btn_n,
  output logic        joy_int,
  output logic [7:0]  dbtn
);

  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic [7:0]    s1;
  logic [7:0]    s2;
  logic [7:0]    stable;      // debounced level, active-low like btn_n
  logic [CW-1:0] cnt [8];
  logic [1:0]    sel;
  logic [3:0]    prev_nib;
  logic [3:0]    nib;
  logic [3:0]    dir;
  logic [3:0]    act;
  logic          hit;
  logic          unused_outdata;

  assign hit            = (address == 16'hff00);
  assign unused_outdata = ^{outdata[7:6], outdata[3:0]};

  // Two-stage synchroniser for the asynchronous button inputs
  always_ff @(posedge clock) begin
    if (!resetn) begin
      s1 <= '1;
      s2 <= '1;
    end else begin
      s1 <= btn_n;
      s2 <= s1;
    end
  end

  // Per-bit debounce: accept a new level only after DEBOUNCE consecutive differing samples
  always_ff @(posedge clock) begin
    if (!resetn) begin
      stable <= '1;
      for (int unsigned i = 0; i < 8; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign dbtn = ~stable;
  assign dir  = dbtn[3:0];
  assign act  = dbtn[7:4];

  // Selected-group nibble, active-low; a set sel bit deselects its group
  always_comb begin
    nib = ~((sel[0] ? 4'h0 : dir) | (sel[1] ? 4'h0 : act));
  end

  // Read mux; zero when not addressed since the top level ORs peripheral data
  always_comb begin
    data = 8'h00;
    if (load && hit) data = {2'b11, sel, nib};
  end

  // P1 group select register
  always_ff @(posedge clock) begin
    if (!resetn) begin
      sel <= 2'b11;
    end else if (store && hit) begin
      sel <= outdata[5:4];
    end
  end

  // Interrupt on any falling nibble bit, registered one cycle after the change
  always_ff @(posedge clock) begin
    if (!resetn) begin
      prev_nib <= 4'hf;
      joy_int  <= 1'b0;
    end else begin
      prev_nib <= nib;
      joy_int  <= |(prev_nib & ~nib);
    end
  end

endmodule
